// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory bank port among NREQ requesters.
// Ports: req/lock/we_in/addr_in/wdata_in in, gnt/rvalid/rdata out, mem_* bank side.
module mem_port_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 32,
    parameter int AW       = 9,
    parameter int MAXBURST = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ-1:0]       we_in,
    input  logic [NREQ*AW-1:0]    addr_in,
    input  logic [NREQ*WIDTH-1:0] wdata_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rvalid,
    output logic [WIDTH-1:0]      rdata,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_a,
    output logic [WIDTH-1:0]      mem_wd,
    input  logic [WIDTH-1:0]      mem_rd
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAXBURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [NREQ-1:0]   rvalid_q, rvalid_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;

    logic              found;
    logic [PW-1:0]     win;
    logic              sel_valid;
    logic [PW-1:0]     sel;
    logic [BW-1:0]     beat_inc;

    // Rotating priority search starting at ptr_q.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (int'(ptr_q) + k) % NREQ;
            if (!found && req[j]) begin
                found = 1'b1;
                win   = PW'(j);
            end
        end
    end

    // Access selection; everything on the bank side is forced quiet in reset.
    always_comb begin
        sel_valid = 1'b0;
        sel       = '0;
        if (state_q == OWNED) begin
            sel_valid = req[owner_q];
            sel       = owner_q;
        end else begin
            sel_valid = found;
            sel       = win;
        end
        if (!rst_n) begin
            sel_valid = 1'b0;
        end
    end

    always_comb begin
        gnt    = '0;
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        if (sel_valid) begin
            gnt[sel] = 1'b1;
            mem_we   = we_in[sel];
            mem_a    = addr_in[sel*AW +: AW];
            mem_wd   = wdata_in[sel*WIDTH +: WIDTH];
        end
    end

    assign beat_inc = BW'(beat_cnt_q + BW'(1));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    ptr_d = (sel == PW'(NREQ - 1)) ? '0 : PW'(sel + 1'b1);
                    if (lock[sel] && (MAXBURST > 1)) begin
                        state_d    = OWNED;
                        owner_d    = sel;
                        beat_cnt_d = BW'(1);
                    end
                end
            end
            OWNED: begin
                if (req[owner_q]) begin
                    beat_cnt_d = beat_inc;
                    // Forced release bounds how long others can starve.
                    if (!lock[owner_q] || (beat_inc == BW'(MAXBURST))) begin
                        state_d = IDLE;
                    end
                end else if (!lock[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data is captured at the edge that ends the grant cycle.
    always_comb begin
        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (sel_valid && !we_in[sel]) begin
            rvalid_d[sel] = 1'b1;
            rdata_d       = mem_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of per-cycle vectors plus a reset-mid-read sequence.
// Uses a local comb-read / posedge-write memory model behind the bank port.
module tb_mem_port_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int AW    = 9;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req, lock, we_in;
    logic [NREQ*AW-1:0]    addr_in;
    logic [NREQ*WIDTH-1:0] wdata_in;
    logic [NREQ-1:0]       gnt, rvalid;
    logic [WIDTH-1:0]      rdata;
    logic                  mem_we;
    logic [AW-1:0]         mem_a;
    logic [WIDTH-1:0]      mem_wd;
    logic [WIDTH-1:0]      mem_rd;

    logic [WIDTH-1:0] mem [512];

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .AW(AW), .MAXBURST(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req(req), .lock(lock), .we_in(we_in),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a];
    always @(posedge clk) begin
        if (mem_we) mem[mem_a] <= mem_wd;
    end

    typedef struct {
        logic [3:0]   req;
        logic [3:0]   lock;
        logic [3:0]   we;
        logic [35:0]  addr;
        logic [127:0] wd;
        logic [3:0]   e_gnt;
        logic         e_we;
        logic [8:0]   e_a;
        logic [31:0]  e_wd;
        logic [3:0]   e_rv;
        logic [31:0]  e_rd;
    } vec_t;

    vec_t tv[$];

    localparam logic [35:0] DA = {9'd23, 9'd22, 9'd21, 9'd20};

    function automatic logic [31:0] rv_of(int a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    task automatic add(input logic [3:0] r, input logic [3:0] l,
                       input logic [3:0] w, input logic [35:0] a,
                       input logic [127:0] d, input logic [3:0] eg,
                       input logic ew, input logic [8:0] ea,
                       input logic [31:0] ed, input logic [3:0] erv,
                       input logic [31:0] erd);
        vec_t v;
        v.req = r; v.lock = l; v.we = w; v.addr = a; v.wd = d;
        v.e_gnt = eg; v.e_we = ew; v.e_a = ea; v.e_wd = ed;
        v.e_rv = erv; v.e_rd = erd;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = rv_of(i);
        mem[5] = 32'h0000_00A5;
        rst_n = 1'b0;
        req = '0; lock = '0; we_in = '0; addr_in = '0; wdata_in = '0;

        // Single read of addr 5 by requester 0.
        add(4'h1, 4'h0, 4'h0, {9'd23, 9'd22, 9'd21, 9'd5}, '0,
            4'h1, 1'b0, 9'd5, 32'h0, 4'h1, 32'hA5);
        // Requester 3 alone moves ptr back to 0.
        add(4'h8, 4'h0, 4'h0, DA, '0, 4'h8, 1'b0, 9'd23, 32'h0, 4'h8, rv_of(23));
        // All request, no lock: 0,1,2,3,0.
        add(4'hF, 4'h0, 4'h0, DA, '0, 4'h1, 1'b0, 9'd20, 32'h0, 4'h1, rv_of(20));
        add(4'hF, 4'h0, 4'h0, DA, '0, 4'h2, 1'b0, 9'd21, 32'h0, 4'h2, rv_of(21));
        add(4'hF, 4'h0, 4'h0, DA, '0, 4'h4, 1'b0, 9'd22, 32'h0, 4'h4, rv_of(22));
        add(4'hF, 4'h0, 4'h0, DA, '0, 4'h8, 1'b0, 9'd23, 32'h0, 4'h8, rv_of(23));
        add(4'hF, 4'h0, 4'h0, DA, '0, 4'h1, 1'b0, 9'd20, 32'h0, 4'h1, rv_of(20));
        // Lock without req is ignored; rdata holds.
        add(4'h0, 4'h2, 4'h0, DA, '0, 4'h0, 1'b0, 9'd0, 32'h0, 4'h0, rv_of(20));
        // Write then read-after-write by another requester.
        add(4'h1, 4'h0, 4'h1, {9'd23, 9'd22, 9'd21, 9'd10},
            {96'h0, 32'hDEAD_BEEF}, 4'h1, 1'b1, 9'd10, 32'hDEAD_BEEF,
            4'h0, rv_of(20));
        add(4'h2, 4'h0, 4'h0, {9'd23, 9'd22, 9'd10, 9'd20}, '0,
            4'h2, 1'b0, 9'd10, 32'h0, 4'h2, 32'hDEAD_BEEF);
        // Locked burst by 2 with 0 pending: 8 grants then 0.
        for (int i = 0; i < 8; i++) begin
            add(4'h5, 4'h4, 4'h0, DA, '0, 4'h4, 1'b0, 9'd22, 32'h0, 4'h4, rv_of(22));
        end
        add(4'h5, 4'h4, 4'h0, DA, '0, 4'h1, 1'b0, 9'd20, 32'h0, 4'h1, rv_of(20));
        // Owner 1 locks, pauses 2 cycles, resumes, releases; 3 waits.
        add(4'hA, 4'h2, 4'h0, DA, '0, 4'h2, 1'b0, 9'd21, 32'h0, 4'h2, rv_of(21));
        add(4'h8, 4'h2, 4'h0, DA, '0, 4'h0, 1'b0, 9'd0, 32'h0, 4'h0, rv_of(21));
        add(4'h8, 4'h2, 4'h0, DA, '0, 4'h0, 1'b0, 9'd0, 32'h0, 4'h0, rv_of(21));
        add(4'hA, 4'h2, 4'h0, DA, '0, 4'h2, 1'b0, 9'd21, 32'h0, 4'h2, rv_of(21));
        add(4'hA, 4'h0, 4'h0, DA, '0, 4'h2, 1'b0, 9'd21, 32'h0, 4'h2, rv_of(21));
        add(4'h8, 4'h0, 4'h0, DA, '0, 4'h8, 1'b0, 9'd23, 32'h0, 4'h8, rv_of(23));

        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", gnt, 4'h0);
        chk("rst_rvalid", rvalid, 4'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_a", mem_a, 9'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            @(negedge clk);
            req = tv[i].req; lock = tv[i].lock; we_in = tv[i].we;
            addr_in = tv[i].addr; wdata_in = tv[i].wd;
            #1;
            chk($sformatf("v%0d_gnt", i), gnt, tv[i].e_gnt);
            chk($sformatf("v%0d_mem_we", i), mem_we, tv[i].e_we);
            chk($sformatf("v%0d_mem_a", i), mem_a, tv[i].e_a);
            chk($sformatf("v%0d_mem_wd", i), mem_wd, tv[i].e_wd);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rvalid", i), rvalid, tv[i].e_rv);
            chk($sformatf("v%0d_rdata", i), rdata, tv[i].e_rd);
        end

        // Reset asserted in the middle of a read grant cycle.
        @(negedge clk);
        req = 4'h4; lock = '0; we_in = '0; addr_in = DA; wdata_in = '0;
        #1;
        chk("mid_gnt_pre", gnt, 4'h4);
        chk("mid_rvalid_pre", rvalid, 4'h8);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_gnt_rst", gnt, 4'h0);
        chk("mid_rvalid_rst", rvalid, 4'h0);
        chk("mid_mem_a_rst", mem_a, 9'h0);
        chk("mid_rdata_rst", rdata, 32'h0);
        @(posedge clk);
        #1;
        chk("mid_rvalid_drop", rvalid, 4'h0);
        @(negedge clk);
        req = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'h8;
        #1;
        chk("post_gnt", gnt, 4'h8);
        chk("post_mem_a", mem_a, 9'd23);
        @(posedge clk);
        #1;
        chk("post_rvalid", rvalid, 4'h8);
        chk("post_rdata", rdata, rv_of(23));
        @(negedge clk);
        req = 4'h0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
